// File: rtl/rv_writeback.sv
// rv_writeback: writeback stage of the uRV pipeline.
// Takes the registered execute outputs, waits for load data when needed,
// aligns and extends it, and drives the register file write port one cycle
// after the result completes. Requests a stall while a load is outstanding.
// Optional feature macro: URV_WB_BYPASS_EN (combinational forwarding of the
// result completing this cycle to decode). Undefined: byp_* are tied to 0.
module rv_writeback (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  x_fun_i,
  input  logic        x_load_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic        w_stall_req_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic        byp_valid_o,
  output logic [4:0]  byp_rd_o,
  output logic [31:0] byp_value_o
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

  wb_state_t   state_r;
  wb_state_t   state_nxt_s;
  logic [2:0]  fun_r;
  logic [4:0]  rd_r;
  logic [1:0]  addr_r;
  logic        capture_s;
  logic        stall_s;
  logic        comp_s;
  logic [4:0]  comp_rd_s;
  logic [31:0] comp_val_s;
  logic        wr_en_s;
  logic        unused_addr_s;

  // Only the byte offset of the load address matters for alignment.
  assign unused_addr_s = ^x_dm_addr_i[31:2];

  // Select the addressed byte/half/word and sign- or zero-extend it.
  function automatic logic [31:0] align_load(input logic [2:0]  fun,
                                             input logic [1:0]  addr,
                                             input logic [31:0] data);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (addr)
      2'd0:    byte_v = data[7:0];
      2'd1:    byte_v = data[15:8];
      2'd2:    byte_v = data[23:16];
      2'd3:    byte_v = data[31:24];
      default: byte_v = data[7:0];
    endcase
    half_v = addr[1] ? data[31:16] : data[15:0];
    case (fun)
      3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  res_v = {{16{half_v[15]}}, half_v};
      3'b010:  res_v = data;
      3'b100:  res_v = {24'h000000, byte_v};
      3'b101:  res_v = {16'h0000, half_v};
      default: res_v = 32'h0000_0000;
    endcase
    return res_v;
  endfunction

  // Next state, load capture, stall request and the result completing now.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    stall_s     = 1'b0;
    comp_s      = 1'b0;
    comp_rd_s   = 5'd0;
    comp_val_s  = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (x_load_i) begin
          if (dm_load_done_i) begin
            comp_s     = 1'b1;
            comp_rd_s  = x_rd_i;
            comp_val_s = align_load(x_fun_i, x_dm_addr_i[1:0], dm_data_l_i);
          end else begin
            capture_s   = 1'b1;
            stall_s     = 1'b1;
            state_nxt_s = WAIT_LOAD;
          end
        end else if (x_rd_write_i) begin
          comp_s     = 1'b1;
          comp_rd_s  = x_rd_i;
          comp_val_s = x_rd_value_i;
        end else begin
          comp_s = 1'b0;
        end
      end
      WAIT_LOAD: begin
        // Upstream is held; the still-presented load is not re-accepted.
        if (dm_load_done_i) begin
          comp_s      = 1'b1;
          comp_rd_s   = rd_r;
          comp_val_s  = align_load(fun_r, addr_r, dm_data_l_i);
          state_nxt_s = IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // x0 is never written; nothing completes while reset is asserted.
  assign wr_en_s       = comp_s && (comp_rd_s != 5'd0) && !rst_i;
  assign w_stall_req_o = stall_s && !rst_i;

  // State register; reset drops any pending load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Hold the fields of a load that is waiting for memory.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fun_r  <= 3'd0;
      rd_r   <= 5'd0;
      addr_r <= 2'd0;
    end else if (capture_s) begin
      fun_r  <= x_fun_i;
      rd_r   <= x_rd_i;
      addr_r <= x_dm_addr_i[1:0];
    end
  end

  // Register file write port: pulse enable, hold index/value between writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_rd_o       <= 5'd0;
      rf_rd_value_o <= 32'h0000_0000;
      rf_rd_write_o <= 1'b0;
    end else if (wr_en_s) begin
      rf_rd_o       <= comp_rd_s;
      rf_rd_value_o <= comp_val_s;
      rf_rd_write_o <= 1'b1;
    end else begin
      rf_rd_write_o <= 1'b0;
    end
  end

`ifdef URV_WB_BYPASS_EN
  assign byp_valid_o = wr_en_s;
  assign byp_rd_o    = wr_en_s ? comp_rd_s  : 5'd0;
  assign byp_value_o = wr_en_s ? comp_val_s : 32'h0000_0000;
`else
  assign byp_valid_o = 1'b0;
  assign byp_rd_o    = 5'd0;
  assign byp_value_o = 32'h0000_0000;
`endif

endmodule

// File: doc/rv_writeback.md
# rv_writeback

Writeback stage of the uRV pipeline, directly downstream of the execute stage. Consumes the registered execute outputs (destination register, ALU/jump result, load flag, load function, data address), waits for load data from data memory, aligns and sign/zero-extends it, and drives the register file write port one cycle later. Requests a pipeline stall while a load is outstanding and can optionally expose a combinational forwarding path to decode.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- x_fun_i  in  3  load funct3 (`LDST_B`=000, `LDST_H`=001, `LDST_L`=010, BU=100, HU=101)
- x_load_i  in  1  instruction in stage is a load (already kill-qualified)
- x_rd_i  in  5  destination register
- x_rd_value_i  in  32  non-load result
- x_rd_write_i  in  1  non-load result must be written (kill-qualified)
- x_dm_addr_i  in  32  load byte address
- dm_data_l_i  in  32  load data word from data memory
- dm_load_done_i  in  1  dm_data_l_i valid this cycle
- w_stall_req_o  out  1  combinational; holds execute and upstream
- rf_rd_o  out  5  register file write index (registered)
- rf_rd_value_o  out  32  register file write data (registered)
- rf_rd_write_o  out  1  register file write enable (registered)
- byp_valid_o, byp_rd_o, byp_value_o  out  1/5/32  combinational forwarding of the result completing this cycle

## Operation
- FSM states: IDLE, WAIT_LOAD.
- IDLE, x_load_i=1, dm_load_done_i=1: load completes this cycle; stay IDLE.
- IDLE, x_load_i=1, dm_load_done_i=0: capture x_fun_i, x_rd_i, x_dm_addr_i[1:0]; go WAIT_LOAD.
- WAIT_LOAD, dm_load_done_i=0: stay. WAIT_LOAD, dm_load_done_i=1: complete using captured fields; go IDLE. x_* ignored in WAIT_LOAD (upstream is held; the same load is still presented on the completion cycle and is not re-accepted).
- w_stall_req_o = !rst_i && ((IDLE && x_load_i && !dm_load_done_i) || (WAIT_LOAD && !dm_load_done_i)).
- Non-load, IDLE, x_rd_write_i=1: result = x_rd_value_i.
- x_load_i and x_rd_write_i both 1: load wins, x_rd_value_i discarded.
- Load alignment: B/BU select byte addr[1:0] (0 → bits 7:0 … 3 → 31:24); H/HU select half addr[1] (0 → 15:0, 1 → 31:16), addr[0] ignored; L ignores addr[1:0]. B/H sign-extend, BU/HU zero-extend; other funct3 → result 0, write still performed.
- Writes with rd=0 suppressed (enable 0, bypass invalid).
- Completing result registered into rf_rd_o/rf_rd_value_o/rf_rd_write_o at the next edge; with no completion rf_rd_write_o←0, index/value hold.

## Timing
- Reset: state IDLE, rf_rd_o=0, rf_rd_value_o=0, rf_rd_write_o=0, captured fields 0, w_stall_req_o=0, byp_*=0.
- Non-load and zero-wait load: completion in cycle N, rf_rd_write_o=1 in N+1 for one cycle.
- Load with k wait cycles: w_stall_req_o high cycles N..N+k-1, low in N+k (done cycle), rf write in N+k+1.
- Back-to-back completions write on consecutive cycles.
- Reset in WAIT_LOAD: pending load dropped, no write, IDLE next cycle.

## Configuration
- URV_WB_BYPASS_EN defined: byp_valid_o=1 in the completion cycle (rd≠0), byp_rd_o/byp_value_o = aligned result, same cycle, before registration.
- Undefined: byp_valid_o, byp_rd_o, byp_value_o tied 0; no logic generated.

## Test plan
- Reset mid-WAIT_LOAD (LW rd=5, done held 0) → stall drops, rf_rd_write_o never 1, state IDLE.
- ALU result: x_rd_write_i=1, rd=3, value 0x12345678 → next cycle rf_rd_o=3, value 0x12345678, write=1 for one cycle; rd=0 → no write.
- LB addr[1:0]=3, data 0x80FF_0000, done same cycle → no stall, rf value 0xFFFF_FF80; LBU → 0x0000_0080.
- LH addr=0x102, data 0x8001_7FFF, done after 3 cycles → stall exactly 3 cycles, write value 0xFFFF_8001; LHU → 0x0000_8001.
- Load then ALU back-to-back (LW rd=1 data 0xDEADBEEF zero wait, ADD rd=2 value 7) → writes on consecutive cycles, correct values; x_load_i and x_rd_write_i both 1 → load data written.
- With URV_WB_BYPASS_EN: LW rd=4 completes cycle N → byp_valid_o=1, byp_rd_o=4, byp_value_o = loaded word in N; without macro byp_* stay 0.
